// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT datapath: sizes, the complex
// sample type and the base-4 digit reversal used to undo butterfly ordering.
package fft_pkg;

   localparam int NPTS = 16;
   localparam int DW   = 16;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   // Swapping the two base-4 digits maps butterfly output order to bin order.
   function automatic logic [3:0] digit_rev4(input logic [3:0] idx);
      return {idx[1:0], idx[3:2]};
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One 16-entry complex sample bank: synchronous write, combinational read.
// Contents are intentionally not reset; the owner's full flag qualifies them.
module fft_reorder_bank
   import fft_pkg::*;
(
   input  logic        clk,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  cplx_t       wdata,
   input  logic [3:0]  raddr,
   output cplx_t       rdata
);

   cplx_t mem [NPTS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: accepts FFT bins in digit-reversed order and
// streams them out in natural order, one sample per cycle each side.
module fft_out_reorder
   import fft_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_r,
   input  logic [DW-1:0] in_i,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_r,
   output logic [DW-1:0] out_i,
   output logic [3:0]    out_index,
   output logic          out_last
);

   logic [1:0] full;
   logic [1:0] full_nxt;
   logic       wbank;
   logic       rbank;
   logic [3:0] wcnt;
   logic [3:0] rcnt;
   logic       in_xfer;
   logic       out_xfer;
   logic [3:0] waddr;
   cplx_t      wdata;
   cplx_t      rdata0;
   cplx_t      rdata1;
   cplx_t      rdata;

   assign in_ready  = !full[wbank];
   assign out_valid = full[rbank];
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign waddr     = digit_rev4(wcnt);
   assign wdata.re  = in_r;
   assign wdata.im  = in_i;

   fft_reorder_bank u_bank0 (
      .clk   (clk),
      .we    (in_xfer && (wbank == 1'b0)),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rcnt),
      .rdata (rdata0)
   );

   fft_reorder_bank u_bank1 (
      .clk   (clk),
      .we    (in_xfer && (wbank == 1'b1)),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rcnt),
      .rdata (rdata1)
   );

   assign rdata = rbank ? rdata1 : rdata0;

   // Write completion and read completion always target different banks
   // (a full bank is never written), so both updates can apply together.
   always_comb begin
      full_nxt = full;
      if (in_xfer && (wcnt == 4'd15)) begin
         full_nxt[wbank] = 1'b1;
      end
      if (out_xfer && (rcnt == 4'd15)) begin
         full_nxt[rbank] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full  <= 2'b00;
         wbank <= 1'b0;
         rbank <= 1'b0;
         wcnt  <= 4'd0;
         rcnt  <= 4'd0;
      end else begin
         full <= full_nxt;
         if (in_xfer) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
               wbank <= !wbank;
            end
         end
         if (out_xfer) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
               rbank <= !rbank;
            end
         end
      end
   end

   always_comb begin
      out_r     = '0;
      out_i     = '0;
      out_index = '0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_r     = rdata.re;
         out_i     = rdata.im;
         out_index = rcnt;
         out_last  = (rcnt == 4'd15);
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: queue-based frame model plus
// directed literal checks for latency, throughput, stall, reset and extremes.
module tb_fft_out_reorder;
   import fft_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_r = '0;
   logic [DW-1:0] in_i = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_r;
   logic [DW-1:0] out_i;
   logic [3:0]    out_index;
   logic          out_last;

   always #5 clk = ~clk;

   fft_out_reorder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_i     (out_i),
      .out_index (out_index),
      .out_last  (out_last)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string name, input string det);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, det);
      end
   endtask

   // Base-4 digit reversal by plain arithmetic: input position k holds bin rev(k).
   function automatic int rev(input int b);
      return (b % 4) * 4 + b / 4;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] r;
      logic [15:0] i;
      int          idx;
   } exp_t;

   exp_t        q[$];
   logic [15:0] fr[16];
   logic [15:0] fi[16];
   int          fk = 0;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         fk = 0;
      end else begin
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            fr[fk] = in_r;
            fi[fk] = in_i;
            fk++;
            if (fk == 16) begin
               for (int b = 0; b < 16; b++)
                  q.push_back('{r: fr[rev(b)], i: fi[rev(b)], idx: b});
               fk = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;
   int nfr;
   bit ev;
   bit er;

   always @(negedge clk) begin
      if (chk_en) begin
         nfr = (q.size() + 15) / 16;
         ev  = q.size() > 0;
         er  = nfr < 2;
         chk(in_ready === er && out_valid === ev, "handshake",
             $sformatf("in_ready=%0b out_valid=%0b expected %0b %0b", in_ready, out_valid, er, ev));
         if (ev)
            chk(out_r === q[0].r && out_i === q[0].i && out_index === 4'(q[0].idx)
                && out_last === (q[0].idx == 15), "data",
                $sformatf("got r=%h i=%h idx=%0d last=%0b expected r=%h i=%h idx=%0d",
                          out_r, out_i, out_index, out_last, q[0].r, q[0].i, q[0].idx));
         else
            chk(out_r === '0 && out_i === '0 && out_index === 4'd0 && out_last === 1'b0, "gating",
                $sformatf("got r=%h i=%h idx=%0d last=%0b expected zeros",
                          out_r, out_i, out_index, out_last));
      end
   end

   // ---------------- stimulus driver ----------------
   int in_pct = 0;
   int out_pct = 0;
   int budget = 0;
   int mode = 0;
   int k_in = 0;
   bit xfer;
   bit rst_seen;
   int v;

   always @(posedge clk) begin
      xfer     = in_valid && in_ready && !rst;
      rst_seen = rst;
      #1;
      if (rst_seen) k_in = 0;
      else if (xfer) k_in++;
      in_valid = (k_in < budget) && (int'($urandom_range(99)) < in_pct);
      case (mode)
         0: begin
            v    = rev(k_in % 16);
            in_r = 16'(v);
            in_i = 16'(-v);
         end
         1: begin
            in_r = 16'($urandom);
            in_i = 16'($urandom);
         end
         default: begin
            in_r = (k_in % 2 == 0) ? 16'h7FFF : 16'h8000;
            in_i = (k_in % 2 == 0) ? 16'h8000 : 16'h7FFF;
         end
      endcase
      out_ready = int'($urandom_range(99)) < out_pct;
   end

   task automatic wait_drain(input int limit);
      bit done = 1'b0;
      for (int n = 0; n < limit && !done; n++) begin
         @(negedge clk);
         if (k_in >= budget && q.size() == 0 && !out_valid) done = 1'b1;
      end
      chk(done, "drain", $sformatf("timeout k_in=%0d budget=%0d pending=%0d", k_in, budget, q.size()));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int first;
   int last;
   int ocnt;
   int lows;
   int bad;
   bit hit;

   initial begin
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk(in_ready === 1'b1 && out_valid === 1'b0 && out_r === '0 && out_last === 1'b0,
          "reset_state", $sformatf("in_ready=%0b out_valid=%0b out_r=%h expected 1 0 0",
                                   in_ready, out_valid, out_r));
      rst = 1'b0;

      // single frame with the digit-reversed ramp
      mode = 0; in_pct = 100; out_pct = 100; budget = 16;
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge clk);
         if (k_in == 15)
            chk(out_valid === 1'b0, "latency_early", $sformatf("out_valid=%0b expected 0", out_valid));
         if (k_in == 16) hit = 1'b1;
      end
      chk(hit, "first_frame_in", $sformatf("k_in=%0d expected 16", k_in));
      for (int n = 0; n < 16; n++) begin
         chk(out_valid === 1'b1 && out_r === 16'(n) && out_i === 16'(-n) && out_index === 4'(n)
             && out_last === (n == 15), "ramp",
             $sformatf("n=%0d got v=%0b r=%h i=%h idx=%0d last=%0b", n, out_valid, out_r, out_i,
                       out_index, out_last));
         @(negedge clk);
      end
      chk(out_valid === 1'b0, "ramp_end", $sformatf("out_valid=%0b expected 0", out_valid));

      // back-to-back frames
      mode = 1; budget = 80;
      first = -1; last = -1; ocnt = 0; lows = 0;
      for (int n = 0; n < 300 && ocnt < 64; n++) begin
         @(negedge clk);
         if (in_valid && !in_ready) lows++;
         if (out_valid && out_ready) begin
            if (first < 0) first = n;
            last = n;
            ocnt++;
         end
      end
      chk(ocnt == 64 && last - first == 63 && lows == 0, "streaming",
          $sformatf("outputs=%0d span=%0d ready_lows=%0d expected 64 63 0", ocnt, last - first, lows));

      // full stall: two frames with no consumer
      mode = 0; out_pct = 0; budget = 112;
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         if (k_in == 112) hit = 1'b1;
      end
      chk(hit && in_ready === 1'b0, "stall_full", $sformatf("k_in=%0d in_ready=%0b expected 112 0", k_in, in_ready));
      lows = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (in_ready === 1'b0) lows++;
      end
      chk(lows == 5, "stall_hold", $sformatf("in_ready low %0d of 5 cycles", lows));
      out_pct = 100;
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge clk);
         if (out_valid && out_last && out_ready) begin
            hit = 1'b1;
            chk(in_ready === 1'b0, "ready_at_last", $sformatf("in_ready=%0b expected 0", in_ready));
            @(negedge clk);
            chk(in_ready === 1'b1, "ready_after_last", $sformatf("in_ready=%0b expected 1", in_ready));
         end
      end
      chk(hit, "stall_release", "no out_last transfer seen");
      wait_drain(200);

      // random backpressure, 100 frames
      mode = 1; in_pct = 70; out_pct = 60; budget = k_in + 1600;
      wait_drain(20000);

      // reset in the middle of a frame
      mode = 0; in_pct = 100; out_pct = 100; budget = k_in + 7;
      hit = 1'b0;
      for (int n = 0; n < 50 && !hit; n++) begin
         @(negedge clk);
         if (k_in == budget) hit = 1'b1;
      end
      chk(hit, "partial_frame", $sformatf("k_in=%0d expected %0d", k_in, budget));
      budget = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(out_valid === 1'b0 && in_ready === 1'b1, "after_reset",
          $sformatf("out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready));
      budget = 16;
      ocnt = 0;
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) ocnt++;
         if (k_in >= budget && q.size() == 0 && !out_valid) hit = 1'b1;
      end
      chk(hit && ocnt == 16, "reset_frame", $sformatf("outputs=%0d expected 16", ocnt));

      // extremes alternating 7FFF / 8000
      mode = 2; budget = k_in + 32;
      ocnt = 0; bad = 0; hit = 1'b0;
      for (int n = 0; n < 300 && !hit; n++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            ocnt++;
            if (((int'(out_index) / 4) % 2) == 0) begin
               if (out_r !== 16'h7FFF || out_i !== 16'h8000) bad++;
            end else begin
               if (out_r !== 16'h8000 || out_i !== 16'h7FFF) bad++;
            end
         end
         if (k_in >= budget && q.size() == 0 && !out_valid) hit = 1'b1;
      end
      chk(hit && ocnt == 32 && bad == 0, "extremes",
          $sformatf("outputs=%0d wrong=%0d expected 32 0", ocnt, bad));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer for the 16-point radix-4 FFT. The butterfly stages produce the 16 frequency bins in base-4 digit-reversed order; this block accepts one complex sample per cycle in that order and returns the same frame in natural bin order (X[0]..X[15]) over a valid/ready stream. It sits between the last butterfly stage and the downstream consumer. Two banks are used in ping-pong so the FFT can write frame n+1 while frame n drains.

## Interface
- DW, 16, sample width of each real and imaginary component (signed two's complement)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept an input sample
- in_r, in_i  in  DW  input sample, arriving in digit-reversed order
- out_valid  out  1  output sample present
- out_ready  in  1  consumer accepts the output sample
- out_r, out_i  out  DW  output sample, in natural order
- out_index  out  4  natural bin index of the current output (0..15)
- out_last  out  1  high with bin 15 of each frame

## Operation
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage: two banks of 16 entries each, each entry 2*DW bits. Each bank has a full flag. State pointers: wbank and rbank (1 bit each), wcnt and rcnt (4 bits each).
- Write side:
  - in_ready = !full[wbank].
  - On an input transfer, the sample is written to bank wbank at address digit_rev4(wcnt) = {wcnt[1:0], wcnt[3:2]}, and wcnt increments.
  - On the transfer with wcnt==15: full[wbank] sets, wbank toggles, and wcnt wraps to 0.
- Read side:
  - out_valid = full[rbank].
  - {out_r, out_i} = bank[rbank][rcnt]; out_index = rcnt; out_last = out_valid && rcnt==15.
  - On an output transfer, rcnt increments.
  - On the transfer with rcnt==15: full[rbank] clears, rbank toggles, and rcnt wraps to 0.
- Gating: while out_valid=0, out_r, out_i, out_index and out_last are driven to 0.
- Simultaneous events: the write side and the read side update independently in the same cycle, including when one bank completes a write while the other completes a read. A bank cannot be written while full, so a write never overwrites undrained data.
- Data path: there is no arithmetic on the samples; they pass through bit-exact.
- Reset: full[0] and full[1] are 0, wbank=rbank=0, wcnt=rcnt=0. The outputs are then in_ready=1, out_valid=0, and all data outputs are 0. Bank contents are not reset. A reset during a frame discards any partial or undrained frame.

## Timing
- Latency: out_valid rises the cycle after the 16th input transfer of a frame; bin 0 is presented in that cycle.
- Combinational paths: output data comes directly from registers, with no combinational path from in_* to out_*. in_ready depends only on registered state, with no path from out_ready.
- Throughput: with out_ready held at 1 and in_valid held at 1, sustained throughput is 1 sample/cycle in each direction with no bubbles between frames.
- Backpressure: if both banks are full, in_ready stays low until the read side frees its bank. in_ready rises the cycle after the out_last transfer.
- Stall behaviour: while out_ready=0, the output data, out_index and out_valid hold stable.

## Structure
- Shared package fft_pkg holds:
  - constant NPTS=16;
  - constant DW=16;
  - typedef for a complex sample {re, im};
  - function digit_rev4(4-bit index) returning {idx[1:0], idx[3:2]}.
  - The butterfly stages reuse this package.
- Sub-module fft_reorder_bank: one 16-entry bank with a synchronous write port and a combinational read port. It is instantiated twice.
- The top level contains the pointers, counters, full flags and output muxing.

## Test plan
- Single frame:
  - Stimulus: input k carries in_r = digit_rev4(k), in_i = -digit_rev4(k). Examples: k=1 gives 4, k=4 gives 1, k=6 gives 9.
  - Required response: out_r = 0,1,...,15 and out_i = 0,-1,...,-15 in order. out_index matches out_r. out_last is high only on 15. out_valid rises 1 cycle after the 16th input.
- Back-to-back frames:
  - Stimulus: 4 frames streamed continuously, in_valid=1 and out_ready=1.
  - Required response: no in_ready deassertion, 64 consecutive output transfers, each frame in natural order.
- Full stall:
  - Stimulus: out_ready=0 while 2 frames are fed.
  - Required response: in_ready falls after the 32nd transfer and stays low. After out_ready=1, in_ready returns the cycle after the first out_last transfer.
- Random backpressure:
  - Stimulus: random in_valid/out_ready over 100 frames, checked against a reference model.
  - Required response: output data and order match exactly; output data stays stable while stalled.
- Reset mid-frame:
  - Stimulus: assert rst after 7 inputs, then send a full new frame.
  - Required response: out_valid=0 and in_ready=1 in the cycle after reset. The output contains only the new frame, in natural order.
- Extremes:
  - Stimulus: samples 16'sh7FFF and 16'sh8000 alternating.
  - Required response: the values pass through bit-exact at their reordered positions.
